nx_stream_fifo: RTL and testbench

- Elastic valid/ready buffer placed on the host-facing side of the node mesh.
- Two instances are used: one feeds the mesh inbound stream, one drains the mesh outbound stream.
- Decouples host back-pressure from the mesh and absorbs bursts of up to DEPTH messages.
- Data passes through unmodified and in order.

---
 rtl/nx_stream_pkg.sv | 18 +
 rtl/nx_fifo_ptr.sv | 43 ++++
 rtl/nx_stream_fifo.sv | 118 +++++++++++
 tb/tb_nx_stream_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nx_stream_pkg.sv
// Shared stream definitions for the node mesh, the stream FIFOs and the host bridge.
package nx_stream_pkg;

  // Width of one stream word. The mesh, the FIFOs and the host bridge all use this width.
  localparam int STREAM_WIDTH = 32;

  // One stream beat: payload plus its valid qualifier.
  typedef struct packed {
    logic [STREAM_WIDTH-1:0] data;
    logic                    valid;
  } stream_t;

  // True when n is a power of two and at least 2.
  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/nx_fifo_ptr.sv
// FIFO pointer with an extra wrap bit above the index bits.
// Also exposes the value the pointer will take at the next edge.
module nx_fifo_ptr
  import nx_stream_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [AW:0] ptr_o,
  output logic [AW:0] ptr_next_o
);

  logic [AW:0] ptr_q;
  logic [AW:0] ptr_d;

  // Advance by one; leaving the last slot returns the index to 0 and flips the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      if (ptr_q[AW-1:0] == AW'(DEPTH - 1)) begin
        ptr_d = {~ptr_q[AW], {AW{1'b0}}};
      end else begin
        ptr_d = ptr_q + (AW + 1)'(1);
      end
    end
  end

  // Pointer register; synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign ptr_next_o = ptr_d;

endmodule

// File: rtl/nx_stream_fifo.sv
// Elastic valid/ready buffer on the host side of the node mesh.
// Data leaves through a registered head word so rd_data_o never glitches,
// and ready/valid depend only on stored state (no combinational path wr_* -> rd_*).
module nx_stream_fifo
  import nx_stream_pkg::*;
#(
  parameter  int WIDTH       = STREAM_WIDTH,
  parameter  int DEPTH       = 4,
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("nx_stream_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW:0]            wr_ptr;
  logic [AW:0]            wr_ptr_next;
  logic [AW:0]            rd_ptr;
  logic [AW:0]            rd_ptr_next;
  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [WIDTH-1:0]       head_q;
  logic [WIDTH-1:0]       head_d;
  logic [LEVEL_WIDTH-1:0] level_q;
  logic [LEVEL_WIDTH-1:0] level_d;

  nx_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (push),
    .ptr_o      (wr_ptr),
    .ptr_next_o (wr_ptr_next)
  );

  nx_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (pop),
    .ptr_o      (rd_ptr),
    .ptr_next_o (rd_ptr_next)
  );

  // Flags come straight from the pointers; handshakes use only these registered-state flags.
  always_comb begin
    empty_o    = (wr_ptr == rd_ptr);
    full_o     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    wr_ready_o = !full_o;
    rd_valid_o = !empty_o;
    push       = wr_valid_i && wr_ready_o;
    pop        = rd_valid_o && rd_ready_i;
  end

  // Storage write; nothing is written during a reset cycle.
  always_comb begin
    mem_d = mem_q;
    if (push && rst_i) begin
      mem_d[wr_ptr[AW-1:0]] = wr_data_i;
    end
  end

  // Head word: follows the read pointer on a pop, or captures the incoming word
  // when that word is about to become the head (FIFO empty after this edge's pop).
  always_comb begin
    head_d = head_q;
    if (pop) begin
      head_d = mem_q[rd_ptr_next[AW-1:0]];
    end
    if (push && (rd_ptr_next == wr_ptr)) begin
      head_d = wr_data_i;
    end
  end

  // Occupancy counter: unchanged on simultaneous push and pop.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
      2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Head and level registers; reset clears the visible output word to 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q  <= '0;
      level_q <= '0;
    end else begin
      head_q  <= head_d;
      level_q <= level_d;
    end
  end

  assign rd_data_o = head_q;
  assign level_o   = level_q;

endmodule

// File: tb/tb_nx_stream_fifo.sv
// Self-checking bench for nx_stream_fifo: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_nx_stream_fifo;
  import nx_stream_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  level;
  logic        full;
  logic        empty;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: the stored words in order, plus whether anything was pushed since reset.
  logic [31:0] mq[$];
  bit          seen = 0;

  nx_stream_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_data_i  (wr_data),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .rd_ready_i (rd_ready),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample 1 unit later.
  task automatic applyStimulus(input logic r, input logic wv, input logic [31:0] wd, input logic rr);
    bit do_push;
    bit do_pop;
    rst      = r;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      seen = 0;
    end else begin
      do_push = wv && (mq.size() < DEPTH);
      do_pop  = rr && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(wd);
        seen = 1;
      end
    end
    #1;
  endtask

  // Compare every output against the reference model.
  task automatic checkOutput(input string tag);
    int n;
    n = mq.size();
    check($sformatf("%s.level", tag), 32'(level), 32'(n));
    check($sformatf("%s.empty", tag), 32'(empty), 32'(n == 0));
    check($sformatf("%s.full", tag), 32'(full), 32'(n == DEPTH));
    check($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'(n != 0));
    check($sformatf("%s.wr_ready", tag), 32'(wr_ready), 32'(n != DEPTH));
    if (n > 0) begin
      check($sformatf("%s.rd_data", tag), rd_data, mq[0]);
    end else if (!seen) begin
      check($sformatf("%s.rd_data_rst", tag), rd_data, 32'h0);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic wv, input logic [31:0] wd,
                      input logic rr);
    applyStimulus(r, wv, wd, rr);
    checkOutput(tag);
  endtask

  typedef struct {
    string       name;
    logic        r;
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    int          exp_level;
    logic        exp_valid;
    logic        exp_full;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] head_before;
    bit          will_pop;

    // Fill-and-drain vectors with hand-computed expectations.
    vecs[0]  = '{"v_reset",   1'b0, 1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{"v_push1",   1'b1, 1'b1, 32'h1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 32'h1};
    vecs[2]  = '{"v_push2",   1'b1, 1'b1, 32'h2, 1'b0, 2, 1'b1, 1'b0, 1'b1, 32'h1};
    vecs[3]  = '{"v_push3",   1'b1, 1'b1, 32'h3, 1'b0, 3, 1'b1, 1'b0, 1'b1, 32'h1};
    vecs[4]  = '{"v_push4",   1'b1, 1'b1, 32'h4, 1'b0, 4, 1'b1, 1'b1, 1'b1, 32'h1};
    vecs[5]  = '{"v_push5_x", 1'b1, 1'b1, 32'h5, 1'b0, 4, 1'b1, 1'b1, 1'b1, 32'h1};
    vecs[6]  = '{"v_pop1",    1'b1, 1'b0, 32'h0, 1'b1, 3, 1'b1, 1'b0, 1'b1, 32'h2};
    vecs[7]  = '{"v_pop2",    1'b1, 1'b0, 32'h0, 1'b1, 2, 1'b1, 1'b0, 1'b1, 32'h3};
    vecs[8]  = '{"v_pop3",    1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 32'h4};
    vecs[9]  = '{"v_pop4",    1'b1, 1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"v_pop_x",   1'b1, 1'b0, 32'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 32'h0};

    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Reset held 3 cycles while a write is offered; nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      check($sformatf("rst%0d.wr_ready", i), 32'(wr_ready), 32'd1);
      check($sformatf("rst%0d.rd_valid", i), 32'(rd_valid), 32'd0);
      check($sformatf("rst%0d.level", i), 32'(level), 32'd0);
      check($sformatf("rst%0d.empty", i), 32'(empty), 32'd1);
      check($sformatf("rst%0d.rd_data", i), rd_data, 32'h0);
    end
    step("rst_release", 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    check("rst_release.first", rd_data, 32'hDEADBEEF);

    // Table-driven fill and drain.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].r, vecs[i].wv, vecs[i].wd, vecs[i].rr);
      check({vecs[i].name, ".level"}, 32'(level), 32'(vecs[i].exp_level));
      check({vecs[i].name, ".rd_valid"}, 32'(rd_valid), 32'(vecs[i].exp_valid));
      check({vecs[i].name, ".full"}, 32'(full), 32'(vecs[i].exp_full));
      if (vecs[i].chk_data) check({vecs[i].name, ".rd_data"}, rd_data, vecs[i].exp_data);
      checkOutput({vecs[i].name, ".model"});
    end

    // Streaming: one push and one pop per cycle, level stays at 1.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("stream%0d", i), 1'b1, 1'b1, 32'h10 + 32'(i), 1'b1);
      check($sformatf("stream%0d.data", i), rd_data, 32'h10 + 32'(i));
      check($sformatf("stream%0d.lvl", i), 32'(level), 32'd1);
    end
    step("stream_tail", 1'b1, 1'b0, 32'h0, 1'b1);

    // Full with simultaneous read: only the pop completes, push lands next cycle.
    for (int i = 0; i < 4; i++) step($sformatf("fill%0d", i), 1'b1, 1'b1, 32'hA0 + 32'(i), 1'b0);
    step("full_rw", 1'b1, 1'b1, 32'hAA, 1'b1);
    check("full_rw.level", 32'(level), 32'd3);
    check("full_rw.data", rd_data, 32'hA1);
    step("full_rw_next", 1'b1, 1'b1, 32'hAA, 1'b0);
    check("full_rw_next.level", 32'(level), 32'd4);

    // Back-pressure at level 2: data must hold whenever the cycle had no pop.
    step("bp_drain0", 1'b1, 1'b0, 32'h0, 1'b1);
    step("bp_drain1", 1'b1, 1'b0, 32'h0, 1'b1);
    check("bp_start.level", 32'(level), 32'd2);
    for (int i = 0; i < 8; i++) begin
      head_before = mq[0];
      will_pop    = (i % 2) == 1;
      step($sformatf("bp%0d", i), 1'b1, 1'b1, 32'h30 + 32'(i), will_pop);
      if (!will_pop) check($sformatf("bp%0d.hold", i), rd_data, head_before);
    end

    // Mid-operation reset at level 3 with a handshake offered.
    step("mid_pre_rst", 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("mid_fill%0d", i), 1'b1, 1'b1, 32'h50 + 32'(i), 1'b0);
    check("mid_fill.level", 32'(level), 32'd3);
    step("mid_rst", 1'b0, 1'b1, 32'h77, 1'b1);
    check("mid_rst.level", 32'(level), 32'd0);
    check("mid_rst.empty", 32'(empty), 32'd1);
    check("mid_rst.rd_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("mid_idle%0d", i), 1'b1, 1'b0, 32'h0, 1'b1);
      check($sformatf("mid_idle%0d.no_stale", i), 32'(rd_valid), 32'd0);
    end
    step("mid_push", 1'b1, 1'b1, 32'h99, 1'b0);
    check("mid_push.data", rd_data, 32'h99);

    // Randomized traffic against the reference model, with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6),
           $urandom, ($urandom_range(0, 9) < 5));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
